// File: rtl/rf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wport_arbiter
//
// Shares the register file's single write port between the in-order pipeline
// writeback (port A) and a long-latency completion source (port B). Each cycle
// one requester is granted and the winner is captured in a one-entry output
// register that drives the RF write bus, the decode forward/block bus and the
// debug trace. A saturating starvation counter forces B to win after
// STARVE_LIMIT consecutive contested losses.
//
// Parameters:
//   STARVE_LIMIT  consecutive B losses before B is forced to win (0: B always wins)
//   CNT_W         starvation counter width, 2^CNT_W-1 >= STARVE_LIMIT
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   a_valid/a_we/a_dest/a_wdata/a_pc   writeback request, a_ready = accepted
//   b_valid/b_dest/b_wdata/b_pc        long-latency request (always writes),
//                                      b_ready = accepted
//   rf_we/rf_waddr/rf_wdata            registered RF write port
//   arb_fwd_blk_bus                    {rf_we, rf_waddr} for decode interlock
//   debug_wb_*                         registered trace of the slot winner
// -----------------------------------------------------------------------------
module rf_wport_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic        a_we,
    input  logic [4:0]  a_dest,
    input  logic [31:0] a_wdata,
    input  logic [31:0] a_pc,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_dest,
    input  logic [31:0] b_wdata,
    input  logic [31:0] b_pc,
    output logic        b_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [5:0]  arb_fwd_blk_bus,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic             grant_a_s;
    logic             grant_b_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic             out_valid_r;
    logic             out_we_r;
    logic [4:0]       out_dest_r;
    logic [31:0]      out_data_r;
    logic [31:0]      out_pc_r;

    logic             out_valid_nxt_s;
    logic             out_we_nxt_s;
    logic [4:0]       out_dest_nxt_s;
    logic [31:0]      out_data_nxt_s;
    logic [31:0]      out_pc_nxt_s;

    // Grant: B wins when uncontested or once it has lost STARVE_LIMIT times in a row.
    always_comb begin
        grant_b_s = b_valid && (!a_valid || (cnt_r >= LIMIT_C));
        grant_a_s = a_valid && !grant_b_s;
    end

    assign a_ready = grant_a_s;
    assign b_ready = grant_b_s;

    // Starvation counter next state: count contested B losses, clear otherwise.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (grant_b_s || !b_valid) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (grant_a_s) begin
            if (cnt_r >= LIMIT_C) begin
                cnt_nxt_s = LIMIT_C;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Output slot next state: winner payload; payload holds when the slot is idle.
    always_comb begin
        out_valid_nxt_s = 1'b0;
        out_we_nxt_s    = out_we_r;
        out_dest_nxt_s  = out_dest_r;
        out_data_nxt_s  = out_data_r;
        out_pc_nxt_s    = out_pc_r;
        if (grant_b_s) begin
            // B results always write; a GPR 0 target is dropped by the RF itself.
            out_valid_nxt_s = 1'b1;
            out_we_nxt_s    = 1'b1;
            out_dest_nxt_s  = b_dest;
            out_data_nxt_s  = b_wdata;
            out_pc_nxt_s    = b_pc;
        end else if (grant_a_s) begin
            out_valid_nxt_s = 1'b1;
            out_we_nxt_s    = a_we;
            out_dest_nxt_s  = a_dest;
            out_data_nxt_s  = a_wdata;
            out_pc_nxt_s    = a_pc;
        end else begin
            out_valid_nxt_s = 1'b0;
        end
    end

    // State registers; reset drops any pending write immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_we_r    <= 1'b0;
            out_dest_r  <= 5'd0;
            out_data_r  <= 32'd0;
            out_pc_r    <= 32'd0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_we_r    <= out_we_nxt_s;
            out_dest_r  <= out_dest_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_pc_r    <= out_pc_nxt_s;
        end
    end

    // A slot taken by a non-writing A instruction is traced but does not write.
    assign rf_we             = out_valid_r && out_we_r;
    assign rf_waddr          = out_dest_r;
    assign rf_wdata          = out_data_r;
    assign arb_fwd_blk_bus   = {rf_we, out_dest_r};
    assign debug_wb_pc       = out_pc_r;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = out_dest_r;
    assign debug_wb_rf_wdata = out_data_r;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic        a_we;
    logic [4:0]  a_dest;
    logic [31:0] a_wdata;
    logic [31:0] a_pc;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_dest;
    logic [31:0] b_wdata;
    logic [31:0] b_pc;
    logic        b_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [5:0]  arb_fwd_blk_bus;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    // Outputs of the STARVE_LIMIT=0 instance sharing the same inputs
    logic        z_a_ready;
    logic        z_b_ready;
    logic        z_rf_we;
    logic [4:0]  z_rf_waddr;
    logic [31:0] z_rf_wdata;
    logic [5:0]  z_bus;
    logic [31:0] z_pc;
    logic [3:0]  z_wen;
    logic [4:0]  z_wnum;
    logic [31:0] z_wdata;

    int checks = 0;
    int errors = 0;

    rf_wport_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_we(a_we), .a_dest(a_dest), .a_wdata(a_wdata), .a_pc(a_pc),
        .a_ready(a_ready),
        .b_valid(b_valid), .b_dest(b_dest), .b_wdata(b_wdata), .b_pc(b_pc),
        .b_ready(b_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .arb_fwd_blk_bus(arb_fwd_blk_bus),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    rf_wport_arbiter #(.STARVE_LIMIT(0), .CNT_W(3)) dut0 (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_we(a_we), .a_dest(a_dest), .a_wdata(a_wdata), .a_pc(a_pc),
        .a_ready(z_a_ready),
        .b_valid(b_valid), .b_dest(b_dest), .b_wdata(b_wdata), .b_pc(b_pc),
        .b_ready(z_b_ready),
        .rf_we(z_rf_we), .rf_waddr(z_rf_waddr), .rf_wdata(z_rf_wdata),
        .arb_fwd_blk_bus(z_bus),
        .debug_wb_pc(z_pc), .debug_wb_rf_wen(z_wen),
        .debug_wb_rf_wnum(z_wnum), .debug_wb_rf_wdata(z_wdata)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_we = 1'b0; a_dest = 5'd0; a_wdata = 32'd0; a_pc = 32'd0;
        b_valid = 1'b0; b_dest = 5'd0; b_wdata = 32'd0; b_pc = 32'd0;
    endtask

    initial begin
        logic        exp_b;
        logic [31:0] exp_cnt;

        // ---- reset state (asynchronous, before any clock edge) ----
        reset = 1'b1;
        idle_inputs();
        #2;
        chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset_bus", {26'd0, arb_fwd_blk_bus}, 32'd0);
        chk("reset_dbg_pc", debug_wb_pc, 32'd0);
        chk("reset_dbg_wdata", debug_wb_rf_wdata, 32'd0);
        chk("reset_cnt", {29'd0, dut.cnt_r}, 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // ---- A only: three back-to-back writes ----
        for (int i = 1; i <= 3; i++) begin
            a_valid = 1'b1; a_we = 1'b1; a_dest = 5'(i);
            a_wdata = 32'(i * 17); a_pc = 32'h0000_1000 + 32'(4 * i);
            #1;
            chk("aonly_a_ready", {31'd0, a_ready}, 32'd1);
            chk("aonly_b_ready", {31'd0, b_ready}, 32'd0);
            tick();
            chk("aonly_rf_we", {31'd0, rf_we}, 32'd1);
            chk("aonly_waddr", {27'd0, rf_waddr}, 32'(i));
            chk("aonly_wdata", rf_wdata, 32'(i * 17));
            chk("aonly_dbg_pc", debug_wb_pc, 32'h0000_1000 + 32'(4 * i));
            chk("aonly_dbg_wen", {28'd0, debug_wb_rf_wen}, 32'hF);
        end
        idle_inputs();
        tick();
        chk("idle_rf_we", {31'd0, rf_we}, 32'd0);
        chk("idle_cnt", {29'd0, dut.cnt_r}, 32'd0);

        // ---- B only ----
        b_valid = 1'b1; b_dest = 5'd7; b_wdata = 32'hDEAD_BEEF; b_pc = 32'hBFC0_0100;
        #1;
        chk("bonly_b_ready", {31'd0, b_ready}, 32'd1);
        chk("bonly_a_ready", {31'd0, a_ready}, 32'd0);
        tick();
        idle_inputs();
        chk("bonly_rf_we", {31'd0, rf_we}, 32'd1);
        chk("bonly_waddr", {27'd0, rf_waddr}, 32'd7);
        chk("bonly_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("bonly_dbg_pc", debug_wb_pc, 32'hBFC0_0100);

        // ---- forward bus: B to GPR 9, then an idle cycle ----
        b_valid = 1'b1; b_dest = 5'd9; b_wdata = 32'h0000_0099; b_pc = 32'h0000_2000;
        tick();
        idle_inputs();
        chk("fwd_bus_busy", {26'd0, arb_fwd_blk_bus}, 32'h29);
        tick();
        chk("fwd_bus_idle_we", {31'd0, arb_fwd_blk_bus[5]}, 32'd0);
        chk("fwd_idle_rf_we", {31'd0, rf_we}, 32'd0);

        // ---- starvation: A and B held; A x4, B on 5th, then A with cnt 0 ----
        a_valid = 1'b1; a_we = 1'b1; a_dest = 5'd3; a_wdata = 32'h0000_00A0; a_pc = 32'h0000_3000;
        b_valid = 1'b1; b_dest = 5'd4; b_wdata = 32'h0000_00B0; b_pc = 32'h0000_4000;
        for (int c = 0; c < 6; c++) begin
            exp_b   = (c == 4);
            exp_cnt = (c < 5) ? 32'(c) : 32'd0;
            #1;
            chk("starve_cnt", {29'd0, dut.cnt_r}, exp_cnt);
            chk("starve_a_ready", {31'd0, a_ready}, {31'd0, !exp_b});
            chk("starve_b_ready", {31'd0, b_ready}, {31'd0, exp_b});
            chk("lim0_b_ready", {31'd0, z_b_ready}, 32'd1);
            chk("lim0_a_ready", {31'd0, z_a_ready}, 32'd0);
            tick();
            chk("starve_waddr", {27'd0, rf_waddr}, exp_b ? 32'd4 : 32'd3);
            chk("starve_wdata", rf_wdata, exp_b ? 32'h0000_00B0 : 32'h0000_00A0);
            chk("lim0_cnt", {29'd0, dut0.cnt_r}, 32'd0);
        end
        // last A win while B waited left cnt at 1
        chk("starve_cnt_after", {29'd0, dut.cnt_r}, 32'd1);

        // ---- non-writing A contested with cnt 0 ----
        idle_inputs();
        tick();
        chk("nowr_cnt_pre", {29'd0, dut.cnt_r}, 32'd0);
        a_valid = 1'b1; a_we = 1'b0; a_dest = 5'd6; a_wdata = 32'h0000_0066; a_pc = 32'h0000_0200;
        b_valid = 1'b1; b_dest = 5'd8; b_wdata = 32'h0000_0088; b_pc = 32'h0000_0300;
        #1;
        chk("nowr_a_ready", {31'd0, a_ready}, 32'd1);
        chk("nowr_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        idle_inputs();
        chk("nowr_rf_we", {31'd0, rf_we}, 32'd0);
        chk("nowr_dbg_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        chk("nowr_dbg_pc", debug_wb_pc, 32'h0000_0200);
        chk("nowr_dbg_wnum", {27'd0, debug_wb_rf_wnum}, 32'd6);
        chk("nowr_bus", {26'd0, arb_fwd_blk_bus}, 32'h06);
        chk("nowr_cnt", {29'd0, dut.cnt_r}, 32'd1);
        tick();

        // ---- reset mid-write ----
        a_valid = 1'b1; a_we = 1'b1; a_dest = 5'd5; a_wdata = 32'h0000_0555; a_pc = 32'h0000_0500;
        tick();
        chk("rstmid_pre_rf_we", {31'd0, rf_we}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rstmid_bus", {26'd0, arb_fwd_blk_bus}, 32'd0);
        chk("rstmid_dbg_pc", debug_wb_pc, 32'd0);
        chk("rstmid_dbg_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        chk("rstmid_dbg_wnum", {27'd0, debug_wb_rf_wnum}, 32'd0);
        chk("rstmid_dbg_wdata", debug_wb_rf_wdata, 32'd0);
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
